// File: rtl/cdb_broadcaster.sv
// Purpose : collects results from six producers (add1..add3, mul1, mul2, ls) and broadcasts one per cycle on the CDB.
// Latency : 2 edges from accepted push to broadcast (1 edge via the empty-FIFO bypass when CDB_BYPASS_EN is defined).
// Backpr. : src_ready[i] drops while FIFO i is full; the CDB itself has no backpressure (one-cycle strobes).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   src_req[5:0]      per-source result strobe, bit order {ls, mul2, mul1, add3, add2, add1}
//   src_data          six DATA_W-bit results, slice i = [i*DATA_W +: DATA_W]
//   ls_idx_in[2:0]    load/store entry index, qualified by src_req[5]
//   src_ready[5:0]    per-source accept (FIFO not full, and not in reset)
//   cdb_valid[5:0]    one-hot broadcast strobe
//   cdb_data          broadcast result, 0 when idle
//   cdb_ls_idx[2:0]   load/store index of the broadcast, 0 unless cdb_valid[5]
//
// Build option: define CDB_BYPASS_EN to let a result skip its FIFO when all FIFOs are empty.

module cdb_broadcaster #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            src_req,
    input  logic [6*DATA_W-1:0]   src_data,
    input  logic [2:0]            ls_idx_in,
    output logic [5:0]            src_ready,
    output logic [5:0]            cdb_valid,
    output logic [DATA_W-1:0]     cdb_data,
    output logic [2:0]            cdb_ls_idx
);

    localparam int NSRC = 6;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // FIFO storage; only the ls FIFO carries an index alongside its data
    logic [DATA_W-1:0] r_mem     [NSRC][DEPTH];
    logic [2:0]        r_idx_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr  [NSRC];
    logic [AW-1:0]     r_rd_ptr  [NSRC];
    logic [CW-1:0]     r_count   [NSRC];
    logic [2:0]        r_last_grant;

    logic [5:0]        r_cdb_valid;
    logic [DATA_W-1:0] r_cdb_data;
    logic [2:0]        r_cdb_ls_idx;

    logic [5:0]        w_nonempty;
    logic [5:0]        w_ready;
    logic [5:0]        w_accept;
    logic              w_bypass;
    logic [5:0]        w_cand;
    logic              w_grant_vld;
    logic [2:0]        w_grant_idx;
    logic [5:0]        w_grant_oh;
    logic [5:0]        w_push;
    logic [5:0]        w_pop;
    logic [DATA_W-1:0] w_head_data;
    logic [2:0]        w_head_idx;
    int                w_j;

    always_comb begin
        w_nonempty  = '0;
        w_ready     = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = 3'd0;
        w_j         = 0;

        // Ready looks only at registered counts, so a same-cycle pop never frees a slot
        for (int i = 0; i < NSRC; i++) begin
            w_nonempty[i] = (r_count[i] != '0);
            w_ready[i]    = !rst && (r_count[i] != FULL_CNT);
        end
        w_accept = src_req & w_ready;

`ifdef CDB_BYPASS_EN
        // With every FIFO empty, arbitrate directly among this cycle's accepted requests
        w_bypass = (w_nonempty == '0) && (w_accept != '0);
`else
        w_bypass = 1'b0;
`endif
        w_cand = w_bypass ? w_accept : w_nonempty;

        // Round-robin: scan from the source after the last winner, wrapping at 6
        for (int k = 1; k <= NSRC; k++) begin
            w_j = int'(r_last_grant) + k;
            if (w_j >= NSRC) begin
                w_j = w_j - NSRC;
            end
            if (!w_grant_vld && w_cand[w_j]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = 3'(w_j);
            end
        end

        w_grant_oh = w_grant_vld ? (6'b000001 << w_grant_idx) : 6'b000000;

        if (w_bypass) begin
            w_head_data = src_data[w_grant_idx*DATA_W +: DATA_W];
            w_head_idx  = ls_idx_in;
        end else begin
            w_head_data = r_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
            w_head_idx  = r_idx_mem[r_rd_ptr[5]];
        end

        // A bypassed winner neither pops nor occupies its FIFO
        w_pop  = w_bypass ? 6'b000000 : w_grant_oh;
        w_push = w_accept & ~(w_bypass ? w_grant_oh : 6'b000000);
    end

    assign src_ready  = w_ready;
    assign cdb_valid  = r_cdb_valid;
    assign cdb_data   = r_cdb_data;
    assign cdb_ls_idx = r_cdb_ls_idx;

    // Storage needs no reset: entries are only read while the count says they are live
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
        if (w_push[5]) begin
            r_idx_mem[r_wr_ptr[5]] <= ls_idx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_last_grant <= 3'd5;
            r_cdb_valid  <= '0;
            r_cdb_data   <= '0;
            r_cdb_ls_idx <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end else if (!w_push[i] && w_pop[i]) begin
                    r_count[i] <= r_count[i] - 1'b1;
                end
            end
            r_cdb_valid  <= w_grant_oh;
            r_cdb_data   <= w_grant_vld ? w_head_data : '0;
            r_cdb_ls_idx <= (w_grant_vld && (w_grant_idx == 3'd5)) ? w_head_idx : 3'd0;
            if (w_grant_vld) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

endmodule
